// File: rtl/multicycle_state_ctrl.sv
// Multi-cycle CPU phase sequencer: steps each instruction through IF/ID/EXE/MEM/WB by opcode,
// drives one-hot phase enables and keeps retired-instruction / active-cycle debug counters.
module multicycle_state_ctrl #(
  parameter int         CNT_W   = 32,
  parameter logic [5:0] HALT_OP = 6'b111111
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [5:0]       Opcode,
  output logic [2:0]       STATE_out,
  output logic             IF_clk,
  output logic             ID_clk,
  output logic             ALU_clk,
  output logic             MEM_clk,
  output logic             WB_clk,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EXE  = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd7
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  state_t           state_reg, state_next;
  logic [5:0]       op_q_reg;
  logic [CNT_W-1:0] instr_count_reg, cycle_count_reg;
  logic             retire;
  logic [4:0]       phase;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg       <= S_IF;
      op_q_reg        <= 6'd0;
      instr_count_reg <= '0;
      cycle_count_reg <= '0;
    end else begin
      state_reg <= state_next;
      // Later phases decide on the latched opcode so IR changes after ID cannot redirect the path.
      if (state_reg == S_ID)
        op_q_reg <= Opcode;
      if (state_reg != S_HALT)
        cycle_count_reg <= cycle_count_reg + CNT_W'(1);
      if (retire)
        instr_count_reg <= instr_count_reg + CNT_W'(1);
    end
  end

  always_comb begin
    state_next = state_reg;
    retire     = 1'b0;
    case (state_reg)
      S_IF: state_next = S_ID;
      S_ID: begin
        if (Opcode == HALT_OP) begin
          state_next = S_HALT;
          retire     = 1'b1;
        end else if (Opcode == OP_J) begin
          state_next = S_IF;
          retire     = 1'b1;
        end else begin
          state_next = S_EXE;
        end
      end
      S_EXE: begin
        case (op_q_reg)
          OP_RTYPE, OP_ADDI, OP_ORI, OP_SLTI: state_next = S_WB;
          OP_LW, OP_SW:                       state_next = S_MEM;
          default: begin
            // Branches and unknown opcodes both finish here.
            state_next = S_IF;
            retire     = 1'b1;
          end
        endcase
      end
      S_MEM: begin
        if (op_q_reg == OP_LW) begin
          state_next = S_WB;
        end else begin
          state_next = S_IF;
          retire     = 1'b1;
        end
      end
      S_WB: begin
        state_next = S_IF;
        retire     = 1'b1;
      end
      S_HALT: state_next = S_HALT;
      default: state_next = S_IF;
    endcase
  end

  for (genvar gi = 0; gi < 5; gi++) begin : g_phase
    assign phase[gi] = (state_reg == state_t'(3'(gi)));
  end

  assign STATE_out   = state_reg;
  assign IF_clk      = phase[0];
  assign ID_clk      = phase[1];
  assign ALU_clk     = phase[2];
  assign MEM_clk     = phase[3];
  assign WB_clk      = phase[4];
  assign halted      = (state_reg == S_HALT);
  assign instr_count = instr_count_reg;
  assign cycle_count = cycle_count_reg;

endmodule
